// File: rtl/spi_master_shift_pkg.sv
// spi_master_shift_pkg: shared constants and FSM encoding for the SPI master
// transfer engine.
// Optional feature macro: SPI_LOOPBACK_EN (see spi_master_shift.sv).
package spi_master_shift_pkg;
  localparam int SPI_MAX_CHAR    = 128;
  localparam int SPI_SS_NB       = 8;
  localparam int SPI_DIVIDER_LEN = 16;
  localparam int SPI_CHAR_LEN_W  = 7;

  // Derived widths: character length 1..128, bit index 0..127,
  // edge counter 0..255.
  localparam int SPI_LEN_W  = $clog2(SPI_MAX_CHAR + 1);
  localparam int SPI_IDX_W  = $clog2(SPI_MAX_CHAR);
  localparam int SPI_EDGE_W = SPI_LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } spi_state_e;
endpackage

// File: rtl/spi_master_shift_if.sv
// spi_master_shift_if: host-side control/status bundle of the SPI master.
// The host register block uses the master modport, the engine the slave one.
interface spi_master_shift_if;
  import spi_master_shift_pkg::*;

  logic                       go;
  logic [SPI_CHAR_LEN_W-1:0]  char_len;
  logic [SPI_DIVIDER_LEN-1:0] divider;
  logic                       tx_negedge;
  logic                       rx_negedge;
  logic                       lsb;
  logic                       ass;
  logic [SPI_SS_NB-1:0]       ss;
  logic [SPI_MAX_CHAR-1:0]    tx_data;
  logic [SPI_MAX_CHAR-1:0]    rx_data;
  logic                       busy;
  logic                       done;

  modport master (
    output go, char_len, divider, tx_negedge, rx_negedge, lsb, ass, ss, tx_data,
    input  rx_data, busy, done
  );

  modport slave (
    input  go, char_len, divider, tx_negedge, rx_negedge, lsb, ass, ss, tx_data,
    output rx_data, busy, done
  );
endinterface

// File: rtl/spi_master_shift_clgen.sv
// spi_clgen: sclk divider. While run_i is high the counter counts down from
// divider_i and toggles sclk at zero; pos_edge_o/neg_edge_o flag the cycle
// whose closing clock edge makes sclk rise/fall. sclk is held low otherwise.
module spi_clgen
  import spi_master_shift_pkg::*;
#(
  parameter int DIV_LEN = SPI_DIVIDER_LEN
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               run_i,
  input  logic [DIV_LEN-1:0] divider_i,
  output logic               sclk_o,
  output logic               pos_edge_o,
  output logic               neg_edge_o
);
  logic [DIV_LEN-1:0] cnt_q, cnt_d;
  logic               sclk_q, sclk_d;
  logic               tick;

  assign tick       = run_i && (cnt_q == '0);
  assign pos_edge_o = tick && !sclk_q;
  assign neg_edge_o = tick && sclk_q;
  assign sclk_o     = sclk_q;

  // Next counter/sclk: preload divider while stopped so the first toggle
  // lands divider+1 cycles after run rises.
  always_comb begin
    cnt_d  = divider_i;
    sclk_d = 1'b0;
    if (run_i) begin
      cnt_d  = tick ? divider_i : cnt_q - DIV_LEN'(1);
      sclk_d = tick ? ~sclk_q : sclk_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_master_shift.sv
// spi_master_shift: SPI master transfer engine (FSM, bit counters, tx/rx
// shift paths) on top of spi_clgen.
// Optional feature macro: SPI_LOOPBACK_EN adds a loopback input that makes
// the receive path sample mosi_pad_o instead of miso_pad_i.
module spi_master_shift
  import spi_master_shift_pkg::*;
(
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  spi_master_shift_if.slave      bus,
  output logic                   sclk_pad_o,
  output logic                   mosi_pad_o,
  input  logic                   miso_pad_i,
  output logic [SPI_SS_NB-1:0]   ss_pad_o
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic                   loopback
`endif
);
  spi_state_e                 state_q, state_d;
  logic [SPI_LEN_W-1:0]       len_q, len_d;
  logic [SPI_DIVIDER_LEN-1:0] div_q, div_d;
  logic                       txneg_q, txneg_d;
  logic                       rxneg_q, rxneg_d;
  logic                       lsb_q, lsb_d;
  logic [SPI_MAX_CHAR-1:0]    tx_q, tx_d;
  logic [SPI_MAX_CHAR-1:0]    rx_q, rx_d;
  logic [SPI_IDX_W-1:0]       pos_q, pos_d;
  logic [SPI_IDX_W-1:0]       ridx_q, ridx_d;
  logic [SPI_EDGE_W-1:0]      ecnt_q, ecnt_d;
  logic                       mosi_q, mosi_d;
  logic                       done_q, done_d;

  logic                       pos_edge, neg_edge, run, busy;
  logic                       tx_edge, rx_edge, rx_bit;
  logic [SPI_LEN_W-1:0]       go_len;
  logic [SPI_IDX_W-1:0]       go_last, last_idx;
  logic [SPI_EDGE_W-1:0]      last_edge;
  logic [SPI_DIVIDER_LEN-1:0] clk_div;

  assign run  = (state_q == RUN);
  assign busy = (state_q != IDLE);

  // While idle the divider follows the live input so the counter already
  // holds the latched value on the first RUN cycle.
  assign clk_div = (state_q == IDLE) ? bus.divider : div_q;

  spi_clgen #(.DIV_LEN(SPI_DIVIDER_LEN)) u_clgen (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .run_i      (run),
    .divider_i  (clk_div),
    .sclk_o     (sclk_pad_o),
    .pos_edge_o (pos_edge),
    .neg_edge_o (neg_edge)
  );

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso_pad_i;
`else
  assign rx_bit = miso_pad_i;
`endif

  // char_len of 0 encodes a full-width character.
  assign go_len    = (bus.char_len == '0) ? SPI_LEN_W'(SPI_MAX_CHAR) : SPI_LEN_W'(bus.char_len);
  assign go_last   = SPI_IDX_W'(go_len - SPI_LEN_W'(1));
  assign last_idx  = SPI_IDX_W'(len_q - SPI_LEN_W'(1));
  assign last_edge = {len_q, 1'b0} - SPI_EDGE_W'(1);
  assign tx_edge   = txneg_q ? neg_edge : pos_edge;
  assign rx_edge   = rxneg_q ? neg_edge : pos_edge;

  // Next-state logic: latch on go, step tx/rx on matching sclk edges,
  // finish after 2N edges and pulse done on the way back to IDLE.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    div_d   = div_q;
    txneg_d = txneg_q;
    rxneg_d = rxneg_q;
    lsb_d   = lsb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    pos_d   = pos_q;
    ridx_d  = ridx_q;
    ecnt_d  = ecnt_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A go coinciding with done belongs to the finished transfer.
        if (bus.go && !done_q) begin
          state_d = RUN;
          len_d   = go_len;
          div_d   = bus.divider;
          txneg_d = bus.tx_negedge;
          rxneg_d = bus.rx_negedge;
          lsb_d   = bus.lsb;
          tx_d    = bus.tx_data;
          rx_d    = '0;
          pos_d   = bus.lsb ? '0 : go_last;
          ridx_d  = '0;
          ecnt_d  = '0;
          mosi_d  = bus.tx_data[pos_d];
        end
      end
      RUN: begin
        if (pos_edge || neg_edge) begin
          ecnt_d = ecnt_q + SPI_EDGE_W'(1);
          // First edge only launches sampling; bit 0 is already on mosi.
          if (tx_edge && (ecnt_q != '0)) begin
            if (lsb_q) begin
              if (pos_q != last_idx) pos_d = pos_q + SPI_IDX_W'(1);
            end else if (pos_q != '0) begin
              pos_d = pos_q - SPI_IDX_W'(1);
            end
          end
          if (rx_edge) begin
            if (lsb_q) begin
              rx_d[ridx_q] = rx_bit;
              ridx_d       = ridx_q + SPI_IDX_W'(1);
            end else begin
              rx_d = {rx_q[SPI_MAX_CHAR-2:0], rx_bit};
            end
          end
          if (ecnt_q == last_edge) state_d = FIN;
        end
        mosi_d = tx_q[pos_d];
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      div_q   <= '0;
      txneg_q <= 1'b0;
      rxneg_q <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      pos_q   <= '0;
      ridx_q  <= '0;
      ecnt_q  <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      div_q   <= div_d;
      txneg_q <= txneg_d;
      rxneg_q <= rxneg_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      pos_q   <= pos_d;
      ridx_q  <= ridx_d;
      ecnt_q  <= ecnt_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign mosi_pad_o  = mosi_q;
  // Automatic select follows busy; manual select follows the live mask.
  assign ss_pad_o    = (!bus.ass || busy) ? ~bus.ss : {SPI_SS_NB{1'b1}};
endmodule

// File: tb/tb_spi_master_shift.sv
// tb_spi_master_shift: directed transfers with a scoreboard. The driver pushes
// expected rx_data, mosi sequence, edge count and busy length per transfer;
// the monitor pops and compares on each done pulse.
module tb_spi_master_shift;
  import spi_master_shift_pkg::*;
  localparam int W = SPI_MAX_CHAR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_shift_if bus();
  logic       sclk, mosi, miso;
  logic [SPI_SS_NB-1:0] ssp;
`ifdef SPI_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_master_shift dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus),
    .sclk_pad_o (sclk),
    .mosi_pad_o (mosi),
    .miso_pad_i (miso),
    .ss_pad_o   (ssp)
`ifdef SPI_LOOPBACK_EN
    ,
    .loopback   (loopback)
`endif
  );

  // Slave model: presents sreg[sbit], shifts after each sclk fall.
  logic [W-1:0] sreg = '0;
  logic [6:0]   sbit = '0;
  logic         smsb = 1'b1;
  assign miso = sreg[sbit];
  always @(negedge sclk) sreg = smsb ? (sreg << 1) : (sreg >> 1);

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] mo;
    int           edges;
    int           busyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_exp  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: tracks sclk edges, mosi at each rise and busy length.
  logic [W-1:0] m_mo = '0;
  int  m_edges = 0, m_busy = 0;
  logic prev_sclk = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && !prev_busy) begin
      m_edges = 0; m_busy = 0; m_mo = '0;
    end
    if (sclk !== prev_sclk) begin
      m_edges++;
      if (sclk) m_mo = {m_mo[W-2:0], mosi};
    end
    if (bus.busy) m_busy++;
    if (bus.done === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected actual=1 expected=0");
      end else begin
        e = q.pop_front();
        chk("rx_data", bus.rx_data, e.rx);
        chk("mosi_seq", m_mo, e.mo);
        chk("edges", W'(m_edges), W'(e.edges));
        chk("busy_cycles", W'(m_busy), W'(e.busyc));
      end
    end
    prev_sclk = sclk;
    prev_busy = bus.busy;
  end

  task automatic xfer(input logic [6:0] len, input logic [15:0] div, input logic txn, input logic rxn,
                      input logic ls, input logic [W-1:0] tx, input logic [W-1:0] spat,
                      input logic [6:0] sb, input logic sm, input logic [W-1:0] erx,
                      input logic [W-1:0] emo, input int n, input bit push);
    exp_t e;
    @(negedge clk);
    bus.char_len = len; bus.divider = div; bus.tx_negedge = txn; bus.rx_negedge = rxn;
    bus.lsb = ls; bus.tx_data = tx;
    sreg = spat; sbit = sb; smsb = sm;
    if (push) begin
      e.rx = erx; e.mo = emo; e.edges = 2 * n; e.busyc = 2 * n * (int'(div) + 1) + 1;
      q.push_back(e);
      n_exp++;
    end
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (bus.done !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (bus.done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done expected=done_within_%0d", maxc);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.go = 1'b0; bus.char_len = '0; bus.divider = '0; bus.tx_negedge = 1'b1;
    bus.rx_negedge = 1'b0; bus.lsb = 1'b0; bus.ass = 1'b1; bus.ss = 8'h04; bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", W'(sclk), '0);
    chk("rst_mosi", W'(mosi), '0);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_rx", bus.rx_data, '0);
    chk("rst_ss", W'(ssp), W'(8'hFF));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, MSB first, slave echoes 0x3C.
    xfer(7'd8, 16'd1, 1'b1, 1'b0, 1'b0, W'(8'hA5), W'(8'h3C), 7'd7, 1'b1,
         W'(8'h3C), W'(8'hA5), 8, 1'b1);
    repeat (5) @(negedge clk);
    chk("ss_auto_busy", W'(ssp), W'(8'hFB));
    wait_done(200);
    @(negedge clk);
    chk("ss_auto_idle", W'(ssp), W'(8'hFF));

    // LSB first, 4 bits.
    xfer(7'd4, 16'd1, 1'b1, 1'b0, 1'b1, W'(4'h1), W'(4'h3), 7'd0, 1'b0,
         W'(4'h3), W'(4'h8), 4, 1'b1);
    wait_done(200);

    // Full 128-bit character, fastest sclk.
    xfer(7'd0, 16'd0, 1'b1, 1'b0, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
         128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 7'd127, 1'b1,
         128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
         128'h8000_0000_0000_0000_0000_0000_0000_0001, 128, 1'b1);
    wait_done(1000);

    // Go and input changes mid-transfer, then go in the done cycle.
    xfer(7'd8, 16'd2, 1'b1, 1'b0, 1'b0, W'(8'hC3), W'(8'h96), 7'd7, 1'b1,
         W'(8'h96), W'(8'hC3), 8, 1'b1);
    repeat (10) @(negedge clk);
    bus.tx_data = '1; bus.char_len = 7'd3; bus.divider = 16'd0; bus.lsb = 1'b1; bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_done(300);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (3) @(negedge clk);
    chk("go_in_done_busy", W'(bus.busy), '0);
    chk("go_in_done_sclk", W'(sclk), '0);

    // tx on rising, rx on falling edges, then back-to-back LSB transfer
    // issued the cycle after done; bits above N are ignored both ways.
    xfer(7'd8, 16'd0, 1'b0, 1'b1, 1'b0, W'(8'h6E), W'(8'hB1), 7'd7, 1'b1,
         W'(8'hB1), W'(8'h6E), 8, 1'b1);
    wait_done(200);
    xfer(7'd5, 16'd0, 1'b1, 1'b0, 1'b1, W'(8'hF6), W'(8'hF9), 7'd0, 1'b0,
         W'(5'h19), W'(5'h0D), 5, 1'b1);
    wait_done(200);

    // Manual slave select follows the live mask at all times.
    @(negedge clk);
    bus.ass = 1'b0;
    @(negedge clk);
    chk("ss_manual_idle", W'(ssp), W'(8'hFB));
    xfer(7'd8, 16'd0, 1'b1, 1'b0, 1'b0, W'(8'h00), W'(8'hFF), 7'd7, 1'b1,
         W'(8'hFF), W'(8'h00), 8, 1'b1);
    repeat (3) @(negedge clk);
    chk("ss_manual_busy", W'(ssp), W'(8'hFB));
    wait_done(200);
    bus.ass = 1'b1;

    // Asynchronous reset mid-transfer: abort, no done.
    xfer(7'd8, 16'd3, 1'b1, 1'b0, 1'b0, W'(8'h55), W'(8'h0F), 7'd7, 1'b1,
         '0, '0, 8, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sclk", W'(sclk), '0);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_ss", W'(ssp), W'(8'hFF));
    chk("abort_done", W'(bus.done), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    xfer(7'd8, 16'd1, 1'b1, 1'b0, 1'b0, W'(8'h5A), '0, 7'd7, 1'b1,
         W'(8'h5A), W'(8'h5A), 8, 1'b1);
    wait_done(200);
    loopback = 1'b0;
`endif

    // Recovery transfer after the abort.
    xfer(7'd8, 16'd0, 1'b1, 1'b0, 1'b0, W'(8'h81), W'(8'h7E), 7'd7, 1'b1,
         W'(8'h7E), W'(8'h81), 8, 1'b1);
    wait_done(200);

    repeat (5) @(negedge clk);
    chk("done_count", W'(n_done), W'(n_exp));
    chk("queue_empty", W'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_shift.md
Name: spi_master_shift

Overview:
- Master-side SPI transfer engine: clock divider, serialiser and deserialiser for one character of 1..SPI_MAX_CHAR bits.
- Directly upstream of the SPI slave: drives sclk_pad_o, mosi_pad_o and ss_pad_o, and samples miso_pad_i.
- A host register block loads tx_data and the control fields, pulses go, then reads rx_data after done.

Parameters:
- SPI_MAX_CHAR, 128, maximum character length in bits; also the tx/rx data width.
- SPI_SS_NB, 8, number of slave-select lines.
- SPI_DIVIDER_LEN, 16, width of the clock divider value.

Ports:
- wb_clk_i  in  1  system clock; all logic is posedge.
- wb_rst_n_i  in  1  reset; asynchronous, active-low.
- go  in  1  one-cycle start pulse; ignored while busy=1.
- char_len  in  7  bits per transfer; 0 means 128.
- divider  in  SPI_DIVIDER_LEN  sclk half-period minus 1, in wb_clk_i cycles.
- tx_negedge  in  1  1: mosi changes on sclk falling edges; 0: on rising edges.
- rx_negedge  in  1  1: miso sampled on sclk falling edges; 0: on rising edges.
- lsb  in  1  1: LSB first; 0: MSB first.
- ass  in  1  1: automatic slave select during transfers.
- ss  in  SPI_SS_NB  slave-select enable mask, active-high.
- tx_data  in  SPI_MAX_CHAR  character to send.
- rx_data  out  SPI_MAX_CHAR  received character.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- sclk_pad_o  out  1  serial clock; idles low.
- mosi_pad_o  out  1  serial data out.
- miso_pad_i  in  1  serial data in.
- ss_pad_o  out  SPI_SS_NB  slave selects, active-low.

Behaviour:
- Reset values: sclk_pad_o=0, mosi_pad_o=0, busy=0, done=0, rx_data=0, ss_pad_o=all ones. Reset is asynchronous and takes effect mid-transfer: the transfer is aborted with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE + go:
  - Latch char_len (as N), divider, tx_negedge, rx_negedge, lsb and tx_data.
  - Next cycle: busy=1; mosi_pad_o = bit0, which is tx_data[N-1] when lsb=0 and tx_data[0] when lsb=1.
  - Enter RUN.
- RUN, clock divider:
  - A counter loads the latched divider and counts down once per cycle.
  - At 0 it reloads and toggles sclk_pad_o, so the half-period is divider+1 cycles.
  - divider=0 gives sclk = wb_clk_i/2.
  - The first toggle occurs divider+1 cycles after RUN entry.
- RUN, edges:
  - Exactly 2N edge events per transfer, alternating rise/fall and starting with a rise.
- RUN, transmit:
  - The transmit bit index advances on each edge event matching tx_negedge.
  - The first edge event of the transfer never advances it.
  - The index saturates at N-1.
- RUN, receive:
  - miso_pad_i is sampled on each edge event matching rx_negedge, N samples in total.
  - lsb=0: shift in at the LSB; after N samples the first received bit sits at rx_data[N-1].
  - lsb=1: the first received bit lands at rx_data[0].
  - Bits above N-1 are 0.
  - rx_data updates progressively during the transfer; it is only valid after done.
- FIN: entered on the 2N-th edge (a fall, so sclk is low). On the following cycle: done=1 for one cycle, busy=0, return to IDLE. mosi_pad_o holds its last bit.
- go while busy: ignored. Input changes mid-transfer have no effect; all fields are latched at go.
- Slave select:
  - ass=1: ss_pad_o = ~ss while busy, all ones otherwise.
  - ass=0: ss_pad_o = ~ss at all times, from the live input.
- Back-to-back: go in the same cycle as done is ignored; go on the next cycle is accepted.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the receive path samples mosi_pad_o instead of miso_pad_i.
  - The pads still toggle normally.
- Undefined: the port is absent and receive always uses miso_pad_i.

Decomposition:
- Shared package/defines (spi_defines): SPI_MAX_CHAR, SPI_SS_NB, SPI_DIVIDER_LEN, the char_len width (7), and state encodings IDLE/RUN/FIN.
- Sub-module spi_clgen: divider counter, sclk_pad_o register, and one-cycle pos_edge/neg_edge strobes aligned to sclk toggles. It is enabled by a run input and forces sclk low when disabled.
- spi_master_shift instantiates spi_clgen and contains the FSM, bit counter and shift registers.

Test Plan:
- Mode 0, MSB first:
  - Stimulus: char_len=8, divider=1, tx_negedge=1, rx_negedge=0, tx_data=0xA5; miso driven from a model echoing 0x3C.
  - Response: mosi bits 1,0,1,0,0,1,0,1, each stable across a rise; sclk period 4 cycles; 16 edges; done once; rx_data=0x3C.
- LSB first:
  - Stimulus: char_len=4, lsb=1, tx_data=0x1.
  - Response: mosi sequence 1,0,0,0; a received pattern 1,1,0,0 gives rx_data=0x3.
- 128-bit transfer:
  - Stimulus: char_len=0, divider=0, tx_data=128'h8000...0001.
  - Response: 256 edges; busy high for 256+2 cycles, ±1; first mosi bit 1, last mosi bit 1.
- Slave select:
  - ass=1, ss=0x04: ss_pad_o=0xFB only while busy, 0xFF otherwise.
  - ass=0: ss_pad_o=0xFB constantly.
- Robustness:
  - go pulsed mid-transfer and in the done cycle: ignored, no extra edges.
  - wb_rst_n_i low mid-transfer: sclk=0, busy=0, ss_pad_o=0xFF immediately, no done pulse.
- SPI_LOOPBACK_EN defined:
  - Stimulus: loopback=1, miso tied to 0, tx_data=0x5A, char_len=8.
  - Response: rx_data=0x5A.
